// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl
// Bank-switch scheduler for one ping-pong buffer channel. It counts accepted
// writes into the active write bank and takes reads from the opposite bank.
// When the write bank is closed (full or flushed) and the read bank has been
// drained, it issues a one-cycle switch pulse that swaps the two banks.
//
// Optional feature macro: PINGPONG_CTRL_DROP_DET_EN
//   defined   -> drop_err / drop_cnt track writes offered while wr_ready=0
//   undefined -> drop_err / drop_cnt are tied to 0
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   wr_valid  : producer offers a word
//   wr_ready  : controller accepts a word (accept = wr_valid & wr_ready)
//   wr_addr   : write address inside the write bank
//   wr_bank   : bank currently being written
//   flush     : close a partially filled write bank
//   rd_valid  : read bank holds an unread word
//   rd_ready  : consumer takes a word (take = rd_valid & rd_ready)
//   rd_addr   : read address inside the read bank
//   rd_bank   : bank currently being read (always ~wr_bank)
//   rd_last   : current read word is the last one of the read bank
//   switch    : one-cycle bank-swap pulse
//   drop_err  : sticky flag, a write was offered while not ready
//   drop_cnt  : saturating count of dropped writes
module pingpong_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic                     wr_bank,
  input  logic                     flush,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     rd_bank,
  output logic                     rd_last,
  output logic                     switch,
  output logic                     drop_err,
  output logic [7:0]               drop_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {FILL, FULL, SWAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wr_cnt, rd_cnt, rd_len;
  logic [CW-1:0] wr_cnt_after, rd_cnt_after;
  logic          accept, take;

  // Handshakes complete only on registered readiness, so counts after this
  // cycle are known combinationally for the next-state decision.
  always_comb begin
    accept       = wr_valid & wr_ready;
    take         = rd_valid & rd_ready;
    wr_cnt_after = accept ? wr_cnt + ONE : wr_cnt;
    rd_cnt_after = take   ? rd_cnt + ONE : rd_cnt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A flush counts a same-cycle accept before deciding
  // whether the bank is non-empty; FULL leaves as soon as the read side is
  // drained, including by a take in this very cycle.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if ((accept && wr_cnt_after == FULL_CNT) ||
            (flush && wr_cnt_after != '0)) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (rd_cnt_after == rd_len) begin
          state_next = SWAP;
        end
      end
      SWAP:    state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Output decode, purely from registered state and counters.
  always_comb begin
    wr_ready = (state == FILL);
    switch   = (state == SWAP);
    rd_valid = (rd_cnt < rd_len) && (state != SWAP);
    rd_last  = rd_valid && (rd_cnt == rd_len - ONE);
  end

  // Bank bookkeeping. The swap cycle hands the write count to the read side
  // and restarts both counters on the exchanged banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      rd_len  <= '0;
      wr_bank <= 1'b0;
    end else if (state == SWAP) begin
      rd_len  <= wr_cnt;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      wr_bank <= ~wr_bank;
    end else begin
      wr_cnt <= wr_cnt_after;
      rd_cnt <= rd_cnt_after;
    end
  end

  assign wr_addr = wr_cnt[ADDR_W-1:0];
  assign rd_addr = rd_cnt[ADDR_W-1:0];
  assign rd_bank = ~wr_bank;

`ifdef PINGPONG_CTRL_DROP_DET_EN
  // Drop detection: any offer while not ready is recorded one cycle later;
  // the flag is sticky until reset and the count saturates at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else if (wr_valid && !wr_ready) begin
      drop_err <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`else
  assign drop_err = 1'b0;
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl
// Self-checking bench for pingpong_ctrl with DEPTH=4. A directed sequence
// walks through fill/swap, concurrent read/write, flush, consumer stall,
// drop saturation and mid-operation reset, then randomized traffic follows.
// Every cycle all outputs are compared with a behavioural model that tracks
// bank occupancy as plain integers and flags.
module tb_pingpong_ctrl;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef PINGPONG_CTRL_DROP_DET_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_valid = 1'b0;
  logic              flush = 1'b0;
  logic              rd_ready = 1'b0;
  logic              wr_ready, wr_bank, rd_valid, rd_bank, rd_last, switch, drop_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        drop_cnt;

  int checkCount = 0;
  int errCount   = 0;

  // Model: words written into the open bank, words read / held by the read
  // bank, whether the write bank is closed, and whether a swap is due now.
  int mWrCount, mRdCount, mRdLen, mBank, mDropCnt;
  bit mClosed, mSwapNow, mDropErr;

  pingpong_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .flush(flush),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .rd_last(rd_last), .switch(switch),
    .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mWrCount = 0; mRdCount = 0; mRdLen = 0; mBank = 0;
    mClosed = 1'b0; mSwapNow = 1'b0; mDropErr = 1'b0; mDropCnt = 0;
  endtask

  // One cycle: drive inputs on the falling edge, compare every output with
  // the model, then advance the model to what the rising edge will produce.
  task automatic applyStimulus(input bit wv, input bit fl, input bit rr, input bit rs);
    bit expWrReady, expRdValid, expRdLast, acc, tk, wasClosed;
    @(negedge clk);
    wr_valid = wv; flush = fl; rd_ready = rr; rst = rs;
    #1;
    expWrReady = !mClosed && !mSwapNow;
    expRdValid = !mSwapNow && (mRdCount < mRdLen);
    expRdLast  = expRdValid && (mRdCount == mRdLen - 1);
    checkOutput("wr_ready", 32'(wr_ready), 32'(expWrReady));
    checkOutput("rd_valid", 32'(rd_valid), 32'(expRdValid));
    checkOutput("rd_last",  32'(rd_last),  32'(expRdLast));
    checkOutput("switch",   32'(switch),   32'(mSwapNow));
    checkOutput("wr_bank",  32'(wr_bank),  32'(mBank));
    checkOutput("rd_bank",  32'(rd_bank),  32'(1 - mBank));
    checkOutput("wr_addr",  32'(wr_addr),  32'(mWrCount % DEPTH));
    checkOutput("rd_addr",  32'(rd_addr),  32'(mRdCount % DEPTH));
    checkOutput("drop_err", 32'(drop_err), 32'(mDropErr));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDropCnt));
    if (rs) begin
      modelReset();
    end else begin
      if (DROP_EN && wv && !expWrReady) begin
        mDropErr = 1'b1;
        if (mDropCnt < 255) mDropCnt++;
      end
      if (mSwapNow) begin
        mRdLen   = mWrCount;
        mRdCount = 0;
        mWrCount = 0;
        mBank    = 1 - mBank;
        mSwapNow = 1'b0;
        mClosed  = 1'b0;
      end else begin
        acc = wv && expWrReady;
        tk  = rr && expRdValid;
        wasClosed = mClosed;
        if (acc) mWrCount++;
        if (tk)  mRdCount++;
        if (!wasClosed) begin
          if ((acc && mWrCount == DEPTH) || (fl && mWrCount > 0)) mClosed = 1'b1;
        end else if (mRdCount == mRdLen) begin
          mSwapNow = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1;
    @(posedge clk);
    modelReset();

    // Reset state, then a back-to-back fill with an idle consumer.
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    // Concurrent drain of the swapped bank and refill of the other.
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);
    // Partial bank closed by flush, then flush on an empty bank.
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0);
    // Consumer stall with both banks full, producer pushing throughout.
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0);
    // Reset while FULL with the read bank half drained.
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

    // Randomized traffic with varying producer/consumer rates.
    for (int seg = 0; seg < 20; seg++) begin
      pw = $urandom_range(0, 100);
      pr = $urandom_range(0, 100);
      for (int i = 0; i < 150; i++) begin
        applyStimulus($urandom_range(0, 99) < pw,
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < pr,
                      $urandom_range(0, 999) < 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
